// File: rtl/ula_nibble_seq.sv
// Nibble-serial sequencer for an external 74181-style 4-bit ALU slice.
// Runs WIDTH-bit operations over WIDTH/4 cycles, LSB nibble first, carry chained through a register.
module ula_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_s,
  input  logic             op_m,
  input  logic             op_cin,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cin,
  input  logic [3:0]       alu_f,
  input  logic             alu_cout,
  input  logic             alu_aeqb,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_f,
  output logic             res_cout,
  output logic             res_eq,
  output logic             res_zero
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       s_q;
  logic             m_q, cin_q;
  logic             carry_q;
  logic             eq_acc;
  logic [WIDTH-1:0] acc_f, acc_nx;
  logic [3:0]       a_nib, b_nib;
  logic             accept, run, last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    accept    = 1'b0;
    run       = 1'b0;
    unique case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        run = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign last = (k == K_LAST);

  // Nibble select and result merge are per-nibble muxes on k rather than shifts.
  always_comb begin
    a_nib  = '0;
    b_nib  = '0;
    acc_nx = acc_f;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (k == KW'(i)) begin
        a_nib             = a_q[4*i +: 4];
        b_nib             = b_q[4*i +: 4];
        acc_nx[4*i +: 4]  = alu_f;
      end
    end
  end

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_s   = '0;
    alu_m   = 1'b0;
    alu_cin = 1'b0;
    if (run) begin
      alu_a   = a_nib;
      alu_b   = b_nib;
      alu_s   = s_q;
      alu_m   = m_q;
      // Logic mode never chains: every nibble sees the operation's own carry-in.
      alu_cin = (m_q || (k == '0)) ? cin_q : carry_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      eq_acc   <= 1'b0;
      acc_f    <= '0;
      res_f    <= '0;
      res_cout <= 1'b0;
      res_eq   <= 1'b0;
      res_zero <= 1'b0;
    end else begin
      if (accept) begin
        a_q    <= op_a;
        b_q    <= op_b;
        s_q    <= op_s;
        m_q    <= op_m;
        cin_q  <= op_cin;
        k      <= '0;
        eq_acc <= 1'b1;
      end
      if (run) begin
        acc_f   <= acc_nx;
        carry_q <= alu_cout;
        eq_acc  <= eq_acc & alu_aeqb;
        // Visible result registers load only on the final nibble, so they hold across the next RUN.
        if (last) begin
          res_f    <= acc_nx;
          res_cout <= alu_cout & ~m_q;
          res_eq   <= eq_acc & alu_aeqb;
          res_zero <= (acc_nx == '0);
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ula_nibble_seq.sv
// Bench for ula_nibble_seq: a behavioural 74181 slice closes the loop, and whole-width
// arithmetic/logic reference results are compared against the assembled outputs.
module tb_ula_nibble_seq;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic [3:0]       op_s = '0;
  logic             op_m = 1'b0;
  logic             op_cin = 1'b0;
  logic [3:0]       alu_a, alu_b, alu_s;
  logic             alu_m, alu_cin;
  logic [3:0]       alu_f;
  logic             alu_cout, alu_aeqb;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_f;
  logic             res_cout, res_eq, res_zero;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] last_f = '0;

  ula_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_aeqb(alu_aeqb),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_f(res_f), .res_cout(res_cout), .res_eq(res_eq), .res_zero(res_zero)
  );

  always #5 clk = ~clk;

  // 74181 logic-mode function table, active-high data.
  function automatic logic [WIDTH-1:0] logic_fn(input logic [3:0] s,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (s)
      4'd0:  return ~a;
      4'd1:  return ~(a | b);
      4'd2:  return ~a & b;
      4'd3:  return '0;
      4'd4:  return ~(a & b);
      4'd5:  return ~b;
      4'd6:  return a ^ b;
      4'd7:  return a & ~b;
      4'd8:  return ~a | b;
      4'd9:  return ~(a ^ b);
      4'd10: return b;
      4'd11: return a & b;
      4'd12: return '1;
      4'd13: return a | ~b;
      4'd14: return a | b;
      default: return a;
    endcase
  endfunction

  // Whole-width reference: {carry, result}. Arithmetic mode is the 74181 two-term sum plus carry-in.
  function automatic logic [WIDTH:0] ref_op(input logic [3:0] s, input logic m, input logic cin,
                                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] t1, t2;
    if (m) return {1'b0, logic_fn(s, a, b)};
    t1 = a | (b & {WIDTH{s[0]}}) | (~b & {WIDTH{s[1]}});
    t2 = (a & ~b & {WIDTH{s[2]}}) | (a & b & {WIDTH{s[3]}});
    return {1'b0, t1} + {1'b0, t2} + (WIDTH+1)'(cin);
  endfunction

  // Combinational slice model.
  logic [3:0] t1s, t2s;
  logic [4:0] sums;
  always_comb begin
    t1s      = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    t2s      = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
    sums     = {1'b0, t1s} + {1'b0, t2s} + {4'b0, alu_cin};
    alu_f    = alu_m ? 4'(logic_fn(alu_s, WIDTH'(alu_a), WIDTH'(alu_b))) : sums[3:0];
    alu_cout = sums[4];
    alu_aeqb = (alu_a == alu_b);
  end

  // Drives one op, scrambles op_* after the accept edge, and waits (bounded) for res_valid.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [3:0] s,
                       input logic m, input logic cin,
                       output int lat, output logic [NIB-1:0] cins, output bit held);
    held = 1'b1;
    cins = '0;
    lat  = 0;
    @(negedge clk);
    op_a = a; op_b = b; op_s = s; op_m = m; op_cin = cin; op_valid = 1'b1;
    for (int w = 0; w < 50 && !op_ready; w++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
    op_s = 4'($urandom); op_m = 1'($urandom); op_cin = 1'($urandom);
    while (!res_valid && lat < 50) begin
      cins = cins | (NIB'(alu_cin) << lat);
      if (res_f !== last_f) held = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_res;
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    n_cmp++; if (res_f !== '0) begin n_err++; $display("FAIL reset_res_f: got %h expected 0000", res_f); end
    n_cmp++; if ({res_cout, res_eq, res_zero} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {res_cout, res_eq, res_zero}); end
    n_cmp++; if ({alu_a, alu_b, alu_s, alu_m, alu_cin} !== 14'd0) begin n_err++; $display("FAIL reset_alu: got %h expected 0", {alu_a, alu_b, alu_s, alu_m, alu_cin}); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL reset_op_ready: got %b expected 1", op_ready); end
    last_f = '0;
  endtask

  task automatic test_add_vector;
    int lat; logic [NIB-1:0] cins; bit held;
    do_op(16'h12FF, 16'h0001, 4'b1001, 1'b0, 1'b0, lat, cins, held);
    n_cmp++; if (lat != NIB) begin n_err++; $display("FAIL add_latency: got %0d expected %0d", lat, NIB); end
    n_cmp++; if (cins !== 4'b0110) begin n_err++; $display("FAIL add_cin_chain: got %b expected 0110", cins); end
    n_cmp++; if (res_f !== 16'h1300) begin n_err++; $display("FAIL add_res_f: got %h expected 1300", res_f); end
    n_cmp++; if ({res_cout, res_zero, res_eq} !== 3'b000) begin n_err++; $display("FAIL add_flags: got %b expected 000", {res_cout, res_zero, res_eq}); end
    n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL add_res_hold: got %b expected 1", held); end
    last_f = 16'h1300;
    release_res();
  endtask

  task automatic test_sub;
    int lat; logic [NIB-1:0] cins; bit held;
    do_op(16'h0005, 16'h0007, 4'b0110, 1'b0, 1'b1, lat, cins, held);
    n_cmp++; if (res_f !== 16'hFFFE) begin n_err++; $display("FAIL sub_res_f: got %h expected fffe", res_f); end
    n_cmp++; if ({res_cout, res_zero} !== 2'b00) begin n_err++; $display("FAIL sub_flags: got %b expected 00", {res_cout, res_zero}); end
    n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL sub_res_hold: got %b expected 1", held); end
    last_f = 16'hFFFE;
    release_res();
  endtask

  task automatic test_xor;
    int lat; logic [NIB-1:0] cins; bit held;
    do_op(16'hA5A5, 16'hFFFF, 4'b0110, 1'b1, 1'b0, lat, cins, held);
    n_cmp++; if (res_f !== 16'h5A5A) begin n_err++; $display("FAIL xor_res_f: got %h expected 5a5a", res_f); end
    n_cmp++; if (res_cout !== 1'b0) begin n_err++; $display("FAIL xor_cout: got %b expected 0", res_cout); end
    n_cmp++; if (cins !== 4'b0000) begin n_err++; $display("FAIL xor_cin_chain: got %b expected 0000", cins); end
    last_f = 16'h5A5A;
    release_res();
  endtask

  task automatic test_boundary;
    int lat; logic [NIB-1:0] cins; bit held;
    do_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, lat, cins, held);
    n_cmp++; if (res_f !== 16'h0000) begin n_err++; $display("FAIL wrap_res_f: got %h expected 0000", res_f); end
    n_cmp++; if ({res_cout, res_zero} !== 2'b11) begin n_err++; $display("FAIL wrap_flags: got %b expected 11", {res_cout, res_zero}); end
    last_f = 16'h0000;
    release_res();
    do_op(16'h1234, 16'h1234, 4'b1001, 1'b0, 1'b0, lat, cins, held);
    n_cmp++; if (res_eq !== 1'b1) begin n_err++; $display("FAIL eq_equal: got %b expected 1", res_eq); end
    n_cmp++; if (res_f !== 16'h2468) begin n_err++; $display("FAIL eq_equal_res_f: got %h expected 2468", res_f); end
    last_f = 16'h2468;
    release_res();
    do_op(16'h1234, 16'h1235, 4'b1001, 1'b0, 1'b0, lat, cins, held);
    n_cmp++; if (res_eq !== 1'b0) begin n_err++; $display("FAIL eq_differ: got %b expected 0", res_eq); end
    last_f = 16'h2469;
    release_res();
  endtask

  task automatic test_hold;
    int lat; logic [NIB-1:0] cins; bit held;
    logic [WIDTH:0] exp;
    logic [WIDTH-1:0] a, b;
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    exp = ref_op(4'b1001, 1'b0, 1'b1, a, b);
    do_op(a, b, 4'b1001, 1'b0, 1'b1, lat, cins, held);
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if ({res_valid, op_ready} !== 2'b10) begin n_err++; $display("FAIL hold_handshake[%0d]: got %b expected 10", c, {res_valid, op_ready}); end
      n_cmp++; if ({res_cout, res_f} !== exp) begin n_err++; $display("FAIL hold_result[%0d]: got %h expected %h", c, {res_cout, res_f}, exp); end
      op_valid = 1'($urandom); op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
      @(negedge clk);
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    n_cmp++; if ({res_valid, op_ready} !== 2'b01) begin n_err++; $display("FAIL hold_release: got %b expected 01", {res_valid, op_ready}); end
    n_cmp++; if (res_f !== exp[WIDTH-1:0]) begin n_err++; $display("FAIL hold_after_release: got %h expected %h", res_f, exp[WIDTH-1:0]); end
    last_f = exp[WIDTH-1:0];
  endtask

  task automatic test_reset_abort;
    int lat; logic [NIB-1:0] cins; bit held;
    do_op(16'hFFFF, 16'hFFFF, 4'b1001, 1'b0, 1'b0, lat, cins, held);
    n_cmp++; if ({res_cout, res_eq, res_f} !== {2'b11, 16'hFFFE}) begin n_err++; $display("FAIL pre_abort: got %h expected %h", {res_cout, res_eq, res_f}, {2'b11, 16'hFFFE}); end
    last_f = 16'hFFFE;
    release_res();
    @(negedge clk);
    op_a = 16'h4321; op_b = 16'h1111; op_s = 4'b1001; op_m = 1'b0; op_cin = 1'b0; op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({res_valid, res_cout, res_eq, res_zero} !== 4'b0000) begin n_err++; $display("FAIL abort_flags: got %b expected 0000", {res_valid, res_cout, res_eq, res_zero}); end
    n_cmp++; if (res_f !== '0) begin n_err++; $display("FAIL abort_res_f: got %h expected 0000", res_f); end
    n_cmp++; if ({alu_a, alu_b, alu_s, alu_m, alu_cin} !== 14'd0) begin n_err++; $display("FAIL abort_alu: got %h expected 0", {alu_a, alu_b, alu_s, alu_m, alu_cin}); end
    @(negedge clk);
    rst_n = 1'b1;
    last_f = '0;
    do_op(16'h0001, 16'h0002, 4'b1001, 1'b0, 1'b0, lat, cins, held);
    n_cmp++; if (res_f !== 16'h0003) begin n_err++; $display("FAIL post_abort_res_f: got %h expected 0003", res_f); end
    n_cmp++; if (lat != NIB) begin n_err++; $display("FAIL post_abort_latency: got %0d expected %0d", lat, NIB); end
    n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL post_abort_hold: got %b expected 1", held); end
    last_f = 16'h0003;
    release_res();
  endtask

  task automatic test_random;
    int lat; logic [NIB-1:0] cins; bit held;
    logic [WIDTH-1:0] a, b;
    logic [3:0] s;
    logic m, cin;
    logic [WIDTH:0] exp;
    for (int n = 0; n < 60; n++) begin
      a = WIDTH'($urandom); b = ($urandom_range(0, 3) == 0) ? a : WIDTH'($urandom);
      s = 4'($urandom); m = 1'($urandom); cin = 1'($urandom);
      exp = ref_op(s, m, cin, a, b);
      do_op(a, b, s, m, cin, lat, cins, held);
      n_cmp++; if (res_f !== exp[WIDTH-1:0]) begin n_err++; $display("FAIL rand_res_f[%0d] s=%b m=%b: got %h expected %h", n, s, m, res_f, exp[WIDTH-1:0]); end
      n_cmp++; if (res_cout !== (exp[WIDTH] & ~m)) begin n_err++; $display("FAIL rand_cout[%0d]: got %b expected %b", n, res_cout, exp[WIDTH] & ~m); end
      n_cmp++; if (res_eq !== (a == b)) begin n_err++; $display("FAIL rand_eq[%0d]: got %b expected %b", n, res_eq, a == b); end
      n_cmp++; if (res_zero !== (exp[WIDTH-1:0] == '0)) begin n_err++; $display("FAIL rand_zero[%0d]: got %b expected %b", n, res_zero, exp[WIDTH-1:0] == '0); end
      n_cmp++; if (lat != NIB) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, NIB); end
      n_cmp++; if (cins[0] !== cin) begin n_err++; $display("FAIL rand_cin0[%0d]: got %b expected %b", n, cins[0], cin); end
      n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL rand_res_hold[%0d]: got %b expected 1", n, held); end
      last_f = exp[WIDTH-1:0];
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_res();
    end
  endtask

  initial begin
    test_reset();
    test_add_vector();
    test_sub();
    test_xor();
    test_boundary();
    test_hold();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
